osd_dem_uart_bus_arb: RTL and testbench
=======================================

OSD_DEM_UART_BUS_ARB -- requirements
Module: osd_dem_uart_bus_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of requesters sharing one UART register bus (range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles waited for bus_ack; 0 disables the timeout.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester access request.
REQ-007 SHALL have port req_addr, input, NUM_REQ*3 bits: packed 3-bit register address, requester i at [3i+2:3i].
REQ-008 SHALL have port req_write, input, NUM_REQ bits: 1 = write, 0 = read.
REQ-009 SHALL have port req_wdata, input, NUM_REQ*8 bits: packed write data, requester i at [8i+7:8i].
REQ-010 SHALL have port req_ack, output, NUM_REQ bits: one-hot completion pulse.
REQ-011 SHALL have port req_err, output, 1 bit: completion was a timeout; valid only while req_ack is nonzero.
REQ-012 SHALL have port req_rdata, output, 8 bits: read data; valid only while req_ack is nonzero.
REQ-013 SHALL have port bus_req, output, 1 bit: downstream access strobe, held until ack or timeout.
REQ-014 SHALL have port bus_addr, output, 3 bits: downstream address.
REQ-015 SHALL have port bus_write, output, 1 bit: downstream direction.
REQ-016 SHALL have port bus_wdata, output, 8 bits: downstream write data.
REQ-017 SHALL have port bus_ack, input, 1 bit: downstream completion.
REQ-018 SHALL have port bus_rdata, input, 8 bits: downstream read data, valid with bus_ack.
REQ-019 SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current or last granted requester.

Function
REQ-020 SHALL implement the states IDLE, BUSY, DONE and GAP.
REQ-021 In IDLE with any req_valid set, SHALL select the winner round-robin (search starts at last_grant+1, wraps modulo NUM_REQ), register its addr/write/wdata onto bus_*, set bus_req, load grant_id, clear the timer, and go to BUSY; bus_req is high the cycle after req_valid is sampled.
REQ-022 In IDLE with no req_valid set, SHALL stay in IDLE with bus_req=0.
REQ-023 In BUSY, SHALL hold bus_req and the bus_* fields stable and increment the timer each cycle.
REQ-024 In BUSY with bus_ack=1, SHALL capture bus_rdata, set err=0, drop bus_req, and go to DONE.
REQ-025 In BUSY with TIMEOUT!=0, bus_ack=0 and timer==TIMEOUT-1, SHALL drop bus_req, set rdata=8'hFF and err=1, and go to DONE; bus_ack wins if both occur in the same cycle.
REQ-026 In DONE, SHALL pulse req_ack[grant_id] for exactly one cycle with req_rdata/req_err, update last_grant=grant_id, and go to GAP.
REQ-027 In GAP, SHALL issue no grant, ignore req_valid, and go to IDLE (turnaround so the requester can drop req_valid).
REQ-028 SHALL define the total latency as bus_ack at cycle k giving req_ack at k+1, and a minimum of 4 cycles from grant to the next grant.
REQ-029 SHALL ignore a bus_ack arriving outside BUSY (late ack after a timeout), leaving no state change.
REQ-030 Requesters SHALL hold req_valid and their fields stable from assertion until their req_ack; a req_valid deasserted before grant is dropped without error.
REQ-031 SHALL size the timer as clog2(TIMEOUT+1) bits, saturating; it never wraps.

Reset
REQ-032 On rst=0 at a clock edge, SHALL enter IDLE and set bus_req=0, req_ack=0, req_err=0, req_rdata=0, bus_addr=0, bus_write=0, bus_wdata=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), and timer=0.
REQ-033 Reset asserted mid-BUSY SHALL abort the access with no req_ack issued; bus_req is low the cycle after reset.

Structure
REQ-034 SHALL place the state enum type (IDLE/BUSY/DONE/GAP) and the timeout rdata constant 8'hFF in the shared osd package.
REQ-035 SHALL implement the round-robin priority selection in one sub-module, osd_rr_select (inputs: request vector, last grant; outputs: winner index and found flag), which is purely combinational.

Verification
REQ-036 Single read: req_valid=01, req_addr0=3'd5, bus_ack 3 cycles after bus_req with bus_rdata=8'h60 -> bus_addr=5, bus_write=0, req_ack=01 one cycle later, req_rdata=8'h60, req_err=0.
REQ-037 Contention: req_valid=11 held continuously from reset -> grant order 0,1,0,1; no back-to-back grant to the same requester; each grant followed by GAP.
REQ-038 Timeout: TIMEOUT=4, bus_ack never asserted -> bus_req high exactly 4 cycles, then req_ack pulse with req_err=1 and req_rdata=8'hFF.
REQ-039 Late ack: repeat REQ-038 with bus_ack pulsed 2 cycles after the timeout -> no extra req_ack, state remains IDLE/GAP.
REQ-040 Simultaneous: bus_ack on the same cycle as the timer expiry -> req_err=0 and req_rdata=bus_rdata.
REQ-041 Reset mid-access: rst=0 in the second BUSY cycle of a write (addr 3'd3, wdata 8'h83) -> bus_req=0 next cycle, no req_ack, and the next grant goes to requester 0.

Source files
------------

// File: rtl/osd_dem_uart_bus_arb_pkg.sv
// Shared types and constants for the UART register-bus arbiter.
package osd_dem_uart_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int          ADDR_W        = 3;
  localparam int          DATA_W        = 8;
  localparam logic [7:0]  TIMEOUT_RDATA = 8'hFF;

  // Timer width that still holds TIMEOUT; a disabled timeout keeps one bit.
  function automatic int timer_width(int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/osd_dem_uart_bus_arb_rr_select.sv
// Round-robin winner search: first set request after 'last', wrapping.
module osd_rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      winner,
  output logic               found
);

  logic [IW-1:0] cand;

  // Offsets 1..NUM_REQ so the previous winner is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((int'(last) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/osd_dem_uart_bus_arb.sv
// Arbiter sharing one UART register bus between NUM_REQ requesters,
// with a bounded wait for bus_ack and a turnaround gap between grants.
module osd_dem_uart_bus_arb
  import osd_dem_uart_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*3-1:0]       req_addr,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*8-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       req_err,
  output logic [7:0]                 req_rdata,
  output logic                       bus_req,
  output logic [2:0]                 bus_addr,
  output logic                       bus_write,
  output logic [7:0]                 bus_wdata,
  input  logic                       bus_ack,
  input  logic [7:0]                 bus_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            TW       = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic [TW-1:0]      timer;
  logic               timeout_hit;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[ADDR_W*g +: ADDR_W];
    assign wdata_arr[g] = req_wdata[DATA_W*g +: DATA_W];
  end

  osd_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_select (
    .req    (req_valid),
    .last   (last_grant),
    .winner (win_idx),
    .found  (win_found)
  );

  assign timeout_hit = (TIMEOUT != 0) && (timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // bus_ack takes priority over a timer expiry landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = BUSY;
      BUSY:    if (bus_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    if (state == DONE) begin
      req_ack[grant_id] = 1'b1;
    end
  end

  // Bus fields are latched at grant so requester changes cannot glitch them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_write  <= 1'b0;
      bus_wdata  <= '0;
      grant_id   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      timer      <= '0;
      req_err    <= 1'b0;
      req_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            bus_req   <= 1'b1;
            bus_addr  <= addr_arr[win_idx];
            bus_write <= req_write[win_idx];
            bus_wdata <= wdata_arr[win_idx];
            grant_id  <= win_idx;
            timer     <= '0;
          end
        end
        BUSY: begin
          if (timer != '1) begin
            timer <= timer + 1'b1;
          end
          if (bus_ack) begin
            req_rdata <= bus_rdata;
            req_err   <= 1'b0;
            bus_req   <= 1'b0;
          end else if (timeout_hit) begin
            req_rdata <= TIMEOUT_RDATA;
            req_err   <= 1'b1;
            bus_req   <= 1'b0;
          end
        end
        DONE: begin
          last_grant <= grant_id;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_dem_uart_bus_arb.sv
// Directed, table-driven bench for osd_dem_uart_bus_arb (2 requesters, TIMEOUT=4).
module tb_osd_dem_uart_bus_arb;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [5:0] req_addr;
  logic [1:0] req_write;
  logic [15:0] req_wdata;
  logic [1:0] req_ack;
  logic       req_err;
  logic [7:0] req_rdata;
  logic       bus_req;
  logic [2:0] bus_addr;
  logic       bus_write;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic [0:0] grant_id;

  int compared;
  int mismatched;

  typedef struct {
    logic [1:0] valid;
    logic [2:0] addr0;
    logic [2:0] addr1;
    logic [1:0] write;
    logic [7:0] wd0;
    logic [7:0] wd1;
    int         ackDelay;
    logic [7:0] ackData;
    int         expGrant;
    logic [2:0] expAddr;
    logic       expWrite;
    logic [7:0] expWdata;
    int         expBusy;
    logic       expErr;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs [6];

  osd_dem_uart_bus_arb #(
    .NUM_REQ (2),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_write (bus_write),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = v.valid;
    req_addr  = {v.addr1, v.addr0};
    req_write = v.write;
    req_wdata = {v.wd1, v.wd0};
  endtask

  // One full transaction: grant, BUSY with optional ack, DONE, GAP.
  task automatic runVector(input int n, input vec_t v);
    string tag;
    int    busy;
    tag = $sformatf("v%0d", n);
    applyStimulus(v);
    tick();
    checkOutput({tag, ".bus_req"},   32'(bus_req),   32'd1);
    checkOutput({tag, ".grant_id"},  32'(grant_id),  32'(v.expGrant));
    checkOutput({tag, ".bus_addr"},  32'(bus_addr),  32'(v.expAddr));
    checkOutput({tag, ".bus_write"}, 32'(bus_write), 32'(v.expWrite));
    checkOutput({tag, ".bus_wdata"}, 32'(bus_wdata), 32'(v.expWdata));
    busy = 0;
    while (bus_req === 1'b1 && busy < 20) begin
      if (busy == v.ackDelay) begin
        bus_ack   = 1'b1;
        bus_rdata = v.ackData;
      end
      busy++;
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 8'hEE;
    end
    checkOutput({tag, ".busy_cycles"}, 32'(busy),      32'(v.expBusy));
    checkOutput({tag, ".req_ack"},     32'(req_ack),   32'(2'b01 << v.expGrant));
    checkOutput({tag, ".req_err"},     32'(req_err),   32'(v.expErr));
    checkOutput({tag, ".req_rdata"},   32'(req_rdata), 32'(v.expRdata));
    req_valid = 2'b00;
    tick();
    checkOutput({tag, ".gap_ack"},     32'(req_ack),   32'd0);
    checkOutput({tag, ".gap_bus_req"}, 32'(bus_req),   32'd0);
    tick();
  endtask

  initial begin
    int   grants [4];
    int   cycs   [4];
    int   ng;
    int   busy;
    int   strayAck;
    int   strayReq;
    logic prevReq;
    vec_t r0;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_write  = '0;
    req_wdata  = '0;
    bus_ack    = 1'b0;
    bus_rdata  = 8'hEE;

    // ack 3 cycles after bus_req also coincides with timer expiry (TIMEOUT=4).
    vecs[0] = '{2'b01, 3'd5, 3'd0, 2'b00, 8'h00, 8'h00,  3, 8'h60, 0, 3'd5, 1'b0, 8'h00, 4, 1'b0, 8'h60};
    vecs[1] = '{2'b10, 3'd0, 3'd2, 2'b10, 8'h00, 8'hA5,  0, 8'h11, 1, 3'd2, 1'b1, 8'hA5, 1, 1'b0, 8'h11};
    vecs[2] = '{2'b01, 3'd7, 3'd0, 2'b01, 8'h3C, 8'h00, -1, 8'h00, 0, 3'd7, 1'b1, 8'h3C, 4, 1'b1, 8'hFF};
    vecs[3] = '{2'b11, 3'd1, 3'd6, 2'b00, 8'h11, 8'h22,  1, 8'hC3, 1, 3'd6, 1'b0, 8'h22, 2, 1'b0, 8'hC3};
    vecs[4] = '{2'b11, 3'd1, 3'd6, 2'b01, 8'h44, 8'h22,  2, 8'h5A, 0, 3'd1, 1'b1, 8'h44, 3, 1'b0, 8'h5A};
    vecs[5] = '{2'b10, 3'd0, 3'd4, 2'b00, 8'h00, 8'h00, -1, 8'h00, 1, 3'd4, 1'b0, 8'h00, 4, 1'b1, 8'hFF};

    tick();
    tick();
    checkOutput("rst.bus_req",   32'(bus_req),   32'd0);
    checkOutput("rst.req_ack",   32'(req_ack),   32'd0);
    checkOutput("rst.req_err",   32'(req_err),   32'd0);
    checkOutput("rst.req_rdata", 32'(req_rdata), 32'd0);
    checkOutput("rst.bus_addr",  32'(bus_addr),  32'd0);
    checkOutput("rst.bus_write", 32'(bus_write), 32'd0);
    checkOutput("rst.bus_wdata", 32'(bus_wdata), 32'd0);
    checkOutput("rst.grant_id",  32'(grant_id),  32'd0);
    rst = 1'b1;
    tick();
    checkOutput("idle.bus_req", 32'(bus_req), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runVector(i, vecs[i]);
    end

    // Late ack: timeout, then a stray bus_ack once back in IDLE.
    req_valid = 2'b01;
    req_addr  = 6'o02;
    req_write = 2'b00;
    tick();
    busy = 0;
    while (bus_req === 1'b1 && busy < 20) begin
      busy++;
      tick();
    end
    checkOutput("late.busy_cycles", 32'(busy),    32'd4);
    checkOutput("late.req_ack",     32'(req_ack), 32'd1);
    checkOutput("late.req_err",     32'(req_err), 32'd1);
    req_valid = 2'b00;
    tick();
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 8'h77;
    tick();
    bus_ack   = 1'b0;
    strayAck  = 0;
    strayReq  = 0;
    for (int c = 0; c < 4; c++) begin
      if (req_ack != 2'b00) strayAck++;
      if (bus_req != 1'b0)  strayReq++;
      tick();
    end
    checkOutput("late.stray_ack", 32'(strayAck), 32'd0);
    checkOutput("late.stray_req", 32'(strayReq), 32'd0);

    // Contention: both requesters held valid straight out of reset.
    rst       = 1'b0;
    req_valid = 2'b11;
    req_addr  = 6'o21;
    req_write = 2'b00;
    tick();
    tick();
    checkOutput("cont.rst_bus_req", 32'(bus_req), 32'd0);
    rst     = 1'b1;
    ng      = 0;
    prevReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus_req && !prevReq && ng < 4) begin
        grants[ng] = int'(grant_id);
        cycs[ng]   = c;
        ng++;
      end
      prevReq = bus_req;
      bus_ack = bus_req;
    end
    bus_ack = 1'b0;
    checkOutput("cont.num_grants", 32'(ng), 32'd4);
    for (int g = 0; g < ng; g++) begin
      checkOutput($sformatf("cont.grant%0d", g), 32'(grants[g]), 32'(g % 2));
      if (g > 0) begin
        checkOutput($sformatf("cont.spacing%0d", g), 32'(cycs[g] - cycs[g-1]), 32'd4);
      end
    end
    req_valid = 2'b00;
    for (int c = 0; c < 10; c++) tick();

    // Reset mid-write: requester 1 granted after requester 0 was served.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    r0 = '{2'b01, 3'd1, 3'd0, 2'b00, 8'h00, 8'h00, 0, 8'h42, 0, 3'd1, 1'b0, 8'h00, 1, 1'b0, 8'h42};
    runVector(6, r0);
    req_valid = 2'b10;
    req_addr  = {3'd3, 3'd2};
    req_write = 2'b10;
    req_wdata = {8'h83, 8'h00};
    tick();
    checkOutput("rmid.grant_id",  32'(grant_id),  32'd1);
    checkOutput("rmid.bus_addr",  32'(bus_addr),  32'd3);
    checkOutput("rmid.bus_write", 32'(bus_write), 32'd1);
    checkOutput("rmid.bus_wdata", 32'(bus_wdata), 32'h83);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rmid.bus_req_after", 32'(bus_req),  32'd0);
    checkOutput("rmid.req_ack_after", 32'(req_ack),  32'd0);
    checkOutput("rmid.grant_reset",   32'(grant_id), 32'd0);
    rst       = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    tick();
    checkOutput("rmid.next_bus_req", 32'(bus_req),  32'd1);
    checkOutput("rmid.next_grant",   32'(grant_id), 32'd0);
    checkOutput("rmid.next_addr",    32'(bus_addr), 32'd2);
    bus_ack   = 1'b1;
    bus_rdata = 8'h9C;
    tick();
    bus_ack = 1'b0;
    checkOutput("rmid.next_ack",   32'(req_ack),   32'd1);
    checkOutput("rmid.next_rdata", 32'(req_rdata), 32'h9C);
    req_valid = 2'b00;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
